// File: rtl/div32_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq_if
// Description : Request/response bundle between the EX-stage stall logic and
//               the sequential divider div32_seq.
//               master : requester (drives start/is_signed/dividend/divisor)
//               slave  : divider   (drives busy/done/quotient/remainder/
//                                   div_by_zero)
// Revision    : 1.0 - initial release
// ============================================================================
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
// Module      : div32_seq
// Description : Multi-cycle radix-2 restoring divider servicing DIV/DIVU.
//               One quotient bit per clock; signed or unsigned per request.
//               Latency accept->done is WIDTH+1 edges, one division per
//               WIDTH+3 cycles back-to-back.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - div32_seq_if.slave (start, is_signed, dividend,
//                      divisor in; busy, done, quotient, remainder,
//                      div_by_zero out; all outputs registered)
// Options     : DIV_ZERO_FASTPATH_EN - when defined, a zero divisor seen at
//               accept jumps straight to DONE with the forced results.
// Revision    : 1.0 - initial release
// ============================================================================
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    div32_seq_if.slave      bus
);
    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_quo;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvsr;       // divisor magnitude
    logic [WIDTH-1:0] r_dvd_orig;   // raw dividend, returned on divide-by-zero
    logic [c_CW-1:0]  r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_zero;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    // Operand magnitudes. Negating 0x80..0 yields 0x80..0, which is the
    // correct magnitude when read as unsigned.
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;

    assign w_dvd_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign w_dvs_zero = (bus.divisor == '0);

    // One restoring step. The shifted remainder needs WIDTH+1 bits; since it
    // is below 2*divisor the WIDTH+1-bit difference always lies within the
    // signed range, so its MSB is a reliable "went negative" flag.
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvsr};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_dvd_orig  <= '0;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_rem      <= '0;
                        r_quo      <= w_dvd_mag;
                        r_dvsr     <= w_dvs_mag;
                        r_dvd_orig <= bus.dividend;
                        r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg    <= w_dvd_neg;
                        r_zero     <= w_dvs_zero;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                        if (w_dvs_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_state <= c_CALC;
                        end
`else
                        r_state    <= c_CALC;
`endif
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dvd_orig;
                    end else begin
                        r_quotient  <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                        r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
                    end
                    r_dbz   <= r_zero;
                    r_done  <= 1'b1;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/div32_seq.md
# div32_seq

Multi-cycle 32-bit integer divider built on iterative subtraction, the inverse companion of the pipeline's 32-bit adder. Sits beside the EX stage of the MIPS pipelined CPU and services DIV/DIVU: the stall logic holds issue while `busy` is high and writes HI/LO on `done`. Radix-2 restoring algorithm, one quotient bit per clock, signed or unsigned per request.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.

- `clk` input 1 rising-edge clock
- `rst` input 1 reset; synchronous, active-high
- `start` input 1 request pulse; sampled only in IDLE
- `is_signed` input 1 1 = DIV (two's complement), 0 = DIVU; captured with `start`
- `dividend` input WIDTH numerator; captured with `start`
- `divisor` input WIDTH denominator; captured with `start`
- `busy` output 1 high from the edge after an accepted `start` until `done` deasserts
- `done` output 1 one-cycle pulse; `quotient`/`remainder` valid
- `quotient` output WIDTH result, to LO
- `remainder` output WIDTH result, to HI
- `div_by_zero` output 1 captured divisor was zero; valid with `done`, held until next accept

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `start`=1 accepts the request.
  - Capture operand magnitudes. When signed and negative, take the two's-complement negation; `0x80000000` stays `0x80000000`, treated as unsigned.
  - Capture sign flags: quotient negative = sign(dividend) XOR sign(divisor); remainder negative = sign(dividend).
  - Clear partial remainder, load iteration counter with 0, go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend register} left by one.
  - Trial subtract is a WIDTH+1-bit subtraction. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments. After iteration WIDTH-1, go to FIX.
- FIX:
  - Negate the quotient and/or remainder per the captured flags.
  - When the captured divisor is zero, force quotient = all ones and remainder = original captured dividend, and set `div_by_zero`.
  - Register the outputs, set `done`, go to DONE.
- DONE: `done` deasserts on the next edge, state returns to IDLE, `busy` drops. Results hold until the next accepted `start`.
- Rounding is truncation toward zero. `0x80000000 / -1` signed gives quotient `0x80000000`, remainder 0, with no error flag.
- `start` while busy is ignored, with no queueing.
- The unsigned arithmetic is modulo 2^WIDTH. The trial subtraction carries one guard bit so no borrow is lost.

## Timing
- Accept edge E0. CALC occupies edges E1..E32. FIX occurs at E33, after which `done` is high and results are valid. `done` falls at E34. Latency from accept to `done` is 33 edges (34th cycle counting the `start` cycle).
- `busy` is high from after E0 through the `done` cycle.
- Back-to-back: a new `start` is accepted the first cycle after `done` falls, which makes throughput one division per 35 cycles.
- Reset value of every output is 0, and state is IDLE. A reset asserted mid-operation aborts the operation on that edge: no `done` pulse, outputs cleared. Reset wins over a simultaneous `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DIV_ZERO_FASTPATH_EN`
  - Defined: a zero divisor detected at accept goes directly from E0 to DONE. Forced results and `div_by_zero` are valid after E0, `done` is high in the cycle after E0, and `busy` is high for that single cycle only.
  - Undefined: a zero divisor takes the full 33-edge path and produces the identical forced results at FIX.

## Test plan
- Unsigned 100 / 7 -> quotient 14, remainder 2, `div_by_zero` 0; `done` high exactly 33 edges after accept, one cycle wide.
- Signed -7 / 2 (`0xFFFFFFF9`, 2) -> quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Signed 7 / -2 -> quotient `0xFFFFFFFD`, remainder 1.
- Signed `0x80000000` / `0xFFFFFFFF` -> quotient `0x80000000`, remainder 0. Unsigned `0xFFFFFFFF` / 1 -> quotient `0xFFFFFFFF`, remainder 0.
- 5 / 0 (signed and unsigned) -> quotient `0xFFFFFFFF`, remainder 5, `div_by_zero` 1. `done` arrives at 33 edges, or 1 edge with `DIV_ZERO_FASTPATH_EN`.
- `start` pulsed at cycle 5 of an operation with different operands -> ignored, first result unaffected. `start` the cycle after `done` falls -> accepted.
- `rst` asserted at cycle 10 of CALC -> `busy`, `done`, `quotient`, `remainder`, `div_by_zero` all 0 after that edge. No `done` pulse follows, and the next `start` runs normally.
